// File: rtl/if_buf_pkg.sv
// rtl/if_buf_pkg.sv - shared widths, constants and queue entry type for the fetch buffer (option: IFB_MISALIGN_CHECK_EN)
package if_buf_pkg;

  localparam int REG_BUS       = 32;
  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic BRANCH  = 1'b1;

  localparam logic [REG_BUS-1:0]  ZERO_WORD     = 32'h00000000;
  localparam logic [INST_BUS-1:0] NOP_INST_WORD = 32'h00000013;

  // One queued fetch; the misalign bit only exists when the check is built in
  typedef struct packed {
`ifdef IFB_MISALIGN_CHECK_EN
    logic                     misalign;
`endif
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0]      inst;
  } ifb_entry_t;

  function automatic ifb_entry_t make_entry(input logic [INST_ADDR_BUS-1:0] pc,
                                            input logic [INST_BUS-1:0] inst);
    ifb_entry_t e;
`ifdef IFB_MISALIGN_CHECK_EN
    e.misalign = (pc[1:0] != 2'b00);
`endif
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// rtl/ifb_fifo.sv - synchronous FIFO with synchronous clear, registered count and full/empty flags
module ifb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally at DEPTH; clear wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; stale data left behind by a clear is never read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == DEPTH[AW:0]);
  assign empty = (count == '0);

endmodule

// File: rtl/if_buf.sv
// rtl/if_buf.sv - fetch prefetch queue and IF/ID register (option: IFB_MISALIGN_CHECK_EN adds id_misalign_o)
module if_buf
  import if_buf_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = NOP_INST_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [31:0] inst_i,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        branch_flag_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
`ifdef IFB_MISALIGN_CHECK_EN
  output logic        id_misalign_o,
`endif
  output logic        stallreq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifb_entry_t    in_entry;
  ifb_entry_t    head;
  ifb_entry_t    sel_entry;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          clr;
  logic          enq;
  logic          load_id;
  logic          bubble_id;
  logic          push;
  logic          pop;
  logic          unused_bits;

  assign clr = flush | (branch_flag_i == BRANCH);
  assign enq = ce_i & (stall[0] == NO_STOP) & ~clr;

  // Decode takes the oldest entry; an empty queue lets the live fetch bypass straight through
  assign load_id   = (stall[1] == NO_STOP) & ~clr & (~fifo_empty | enq);
  assign bubble_id = flush
                   | ((stall[1] == NO_STOP) & ~load_id)
                   | ((stall[1] == STOP) & (stall[2] != STOP));
  assign pop       = load_id & ~fifo_empty;
  assign push      = enq & ~(load_id & fifo_empty);

  assign in_entry  = make_entry(pc_i, inst_i);
  assign sel_entry = fifo_empty ? in_entry : head;

  // Built from registered count only, so ctrl sees no combinational path back through stall
  assign stallreq_o = fifo_full;

  assign unused_bits = ^{stall[5:3], fifo_count};

  ifb_fifo #(
    .WIDTH($bits(ifb_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // IF/ID register: bubble, load, or hold while both ID and EX are stalled
  always_ff @(posedge clk) begin
    if (rst || bubble_id) begin
      id_pc_o       <= ZERO_WORD;
      id_inst_o     <= NOP_INST;
      id_valid_o    <= 1'b0;
`ifdef IFB_MISALIGN_CHECK_EN
      id_misalign_o <= 1'b0;
`endif
    end else if (load_id) begin
      id_pc_o       <= sel_entry.pc;
      id_inst_o     <= sel_entry.inst;
      id_valid_o    <= 1'b1;
`ifdef IFB_MISALIGN_CHECK_EN
      id_misalign_o <= sel_entry.misalign;
`endif
    end
  end

  // Fetching into a full queue means ctrl ignored stallreq_o
  enq_not_full: assert property (@(posedge clk) disable iff (rst) !(enq && fifo_full));

endmodule

// File: tb/tb_if_buf.sv
// tb/tb_if_buf.sv - randomized scoreboard bench for if_buf (honours IFB_MISALIGN_CHECK_EN)
module tb_if_buf;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [5:0]  ST_ID = 6'b000110;
  localparam logic [5:0]  ST_IB = 6'b000010;
  localparam logic [5:0]  ST_IF = 6'b000001;
  localparam logic [5:0]  NONE  = 6'b000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        stallreq_o;
`ifdef IFB_MISALIGN_CHECK_EN
  logic        id_misalign_o;
`endif

  always #5 clk = ~clk;

  if_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .ce_i          (ce_i),
    .inst_i        (inst_i),
    .stall         (stall),
    .flush         (flush),
    .branch_flag_i (branch_flag_i),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_valid_o    (id_valid_o),
`ifdef IFB_MISALIGN_CHECK_EN
    .id_misalign_o (id_misalign_o),
`endif
    .stallreq_o    (stallreq_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        mis;
  } ent_t;

  typedef struct {
    ent_t o;
    logic sreq;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  ent_t cur;
  int   total = 0;
  int   bad = 0;

  function automatic ent_t bubble();
    ent_t b;
    b.pc = '0; b.inst = NOP; b.valid = 1'b0; b.mis = 1'b0;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // One fetch cycle: drive inputs, advance the reference model, queue the expected IF/ID state
  task automatic step(input logic r, input logic c, input logic [31:0] p, input logic [5:0] s,
                      input logic fl, input logic br, output logic acc);
    logic [5:0] st;
    ent_t       e;
    exp_t       x;
    @(negedge clk);
    st = s;
    st[0] = s[0] | (mq.size() == DEPTH);
    rst = r; ce_i = c; pc_i = p; inst_i = $urandom; stall = st; flush = fl; branch_flag_i = br;
    e.pc = p; e.inst = inst_i; e.valid = 1'b1; e.mis = (p[1:0] != 2'b00);
    acc = c & !st[0] & !fl & !br & !r;
    if (r || fl) begin
      mq.delete();
      cur = bubble();
    end else begin
      if (br) mq.delete();
      if (!st[1]) begin
        if (br) cur = bubble();
        else begin
          if (acc) mq.push_back(e);
          if (mq.size() > 0) cur = mq.pop_front();
          else cur = bubble();
        end
      end else begin
        if (!st[2]) cur = bubble();
        if (acc) mq.push_back(e);
      end
    end
    x.o = cur;
    x.sreq = (mq.size() == DEPTH);
    exp_q.push_back(x);
  endtask

  // Monitor: compares each cycle's IF/ID state against the queued expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("id_valid", 32'(id_valid_o), 32'(x.o.valid));
        check("id_pc", id_pc_o, x.o.pc);
        check("id_inst", id_inst_o, x.o.inst);
        check("stallreq", 32'(stallreq_o), 32'(x.sreq));
`ifdef IFB_MISALIGN_CHECK_EN
        check("id_misalign", 32'(id_misalign_o), 32'(x.o.mis));
`endif
      end
    end
  end

  initial begin
    logic [31:0] fpc;
    logic        acc;
    cur = bubble();

    step(1, 0, 0, NONE, 0, 0, acc);
    step(1, 0, 0, NONE, 0, 0, acc);

    fpc = 32'h0;
    repeat (3) begin step(0, 1, fpc, NONE, 0, 0, acc); if (acc) fpc += 4; end

    fpc = 32'h10;
    repeat (6) begin step(0, 1, fpc, ST_ID, 0, 0, acc); if (acc) fpc += 4; end
    repeat (6) step(0, 0, fpc, NONE, 0, 0, acc);

    fpc = 32'h40;
    repeat (3) begin step(0, 1, fpc, ST_ID, 0, 0, acc); if (acc) fpc += 4; end
    step(0, 1, fpc, NONE, 0, 1, acc);
    step(0, 1, 32'h100, NONE, 0, 0, acc);
    step(0, 0, 32'h104, NONE, 0, 0, acc);

    fpc = 32'h80;
    repeat (2) begin step(0, 1, fpc, ST_ID, 0, 0, acc); if (acc) fpc += 4; end
    step(0, 1, fpc, ST_ID, 0, 1, acc);
    step(0, 0, fpc, NONE, 0, 0, acc);

    fpc = 32'h200;
    repeat (5) begin step(0, 1, fpc, ST_ID, 0, 0, acc); if (acc) fpc += 4; end
    step(0, 1, fpc, ST_ID, 1, 0, acc);
    step(0, 0, fpc, NONE, 0, 0, acc);

    step(0, 1, 32'h300, NONE, 0, 0, acc);
    step(0, 1, 32'h304, ST_IB, 0, 0, acc);
    step(0, 1, 32'h308, ST_IF, 0, 0, acc);
    step(0, 0, 32'h308, NONE, 0, 0, acc);

    step(0, 1, 32'h22, NONE, 0, 0, acc);
    step(0, 1, 32'h24, NONE, 0, 0, acc);
    step(0, 0, 32'h28, NONE, 0, 0, acc);

    repeat (400) begin
      int         r;
      logic [5:0] s;
      r = $urandom_range(0, 99);
      s = NONE;
      if (r < 25) s = ST_ID;
      else if (r < 30) s = ST_IB;
      else if (r < 36) s = ST_IF;
      step(0, $urandom_range(0, 3) != 0, $urandom, s,
           $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0, acc);
    end

    step(1, 0, 0, NONE, 0, 0, acc);
    @(posedge clk);
    #4;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
